fifo_sync_param: RTL and testbench

- Parametrised single-clock FIFO; next generation of the team's fifo block.
- Adds configurable width/depth, occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer logic in one clock domain; drop-in for the existing fifo when WREQ/WD/RREQ/RD/f/e only are used.

---
 rtl/fifo_sync_param.sv | 109 ++++++++++
 tb/tb_fifo_sync_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count,
// almost-full/empty flags, error pulses and optional FWFT read.
module fifo_sync_param #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = 14,
  parameter int AE_TH = 2,
  parameter int FWFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WREQ,
  input  logic [DW-1:0]            WD,
  input  logic                     RREQ,
  output logic [DW-1:0]            RD,
  output logic                     f,
  output logic                     e,
  output logic                     af,
  output logic                     ae,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] P_ONE  = AW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF   = CW'(AF_TH);
  localparam logic [CW-1:0] C_AE   = CW'(AE_TH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;
  logic          r_udf;

  logic          w_we;
  logic          w_re;

  // Accept decisions come from the registered flags only.
  always_comb begin
    w_we = WREQ && !f;
    w_re = RREQ && !e;
  end

  // Flags are plain decodes of the registered count.
  always_comb begin
    f   = (r_cnt == C_FULL);
    e   = (r_cnt == '0);
    af  = (r_cnt >= C_AF);
    ae  = (r_cnt <= C_AE);
    cnt = r_cnt;
    ovf = r_ovf;
    udf = r_udf;
  end

  // Storage array; not reset, contents are gated by the count.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr] <= WD;
  end

  // Pointers, occupancy and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      if (w_we) r_wptr <= r_wptr + P_ONE;
      if (w_re) r_rptr <= r_rptr + P_ONE;
      unique case ({w_we, w_re})
        2'b10:   r_cnt <= r_cnt + C_ONE;
        2'b01:   r_cnt <= r_cnt - C_ONE;
        default: r_cnt <= r_cnt;
      endcase
      r_ovf <= WREQ && f;
      r_udf <= RREQ && e;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head of queue is shown directly; zero while empty.
    always_comb begin
      RD = e ? '0 : r_mem[r_rptr];
    end
  end else begin : g_reg
    logic [DW-1:0] r_rd;

    // Registered read port; holds on idle or rejected reads.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rd <= '0;
      end else if (w_re) begin
        r_rd <= r_mem[r_rptr];
      end
    end

    always_comb begin
      RD = r_rd;
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param,
// standard-read and FWFT instances driven in parallel.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       WREQ = 1'b0;
  logic       RREQ = 1'b0;
  logic [7:0] WD = 8'h00;

  logic [7:0] rd0, rd1;
  logic       f0, e0, af0, ae0, ovf0, udf0;
  logic       f1, e1, af1, ae1, ovf1, udf1;
  logic [4:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];

  always #5 clk = ~clk;

  fifo_sync_param #(
    .DW(8), .DEPTH(16), .AF_TH(14), .AE_TH(2), .FWFT(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .WREQ(WREQ), .WD(WD), .RREQ(RREQ),
    .RD(rd0), .f(f0), .e(e0), .af(af0), .ae(ae0),
    .cnt(cnt0), .ovf(ovf0), .udf(udf0)
  );

  fifo_sync_param #(
    .DW(8), .DEPTH(16), .AF_TH(14), .AE_TH(2), .FWFT(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .WREQ(WREQ), .WD(WD), .RREQ(RREQ),
    .RD(rd1), .f(f1), .e(e1), .af(af1), .ae(ae1),
    .cnt(cnt1), .ovf(ovf1), .udf(udf1)
  );

  typedef struct {
    logic       wreq;
    logic [7:0] wd;
    logic       rreq;
    logic [4:0] cnt;
    logic       f, e, af, ae, ovf, udf;
    logic [7:0] rd;
  } vec_t;

  vec_t tv[35];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_dut();
    WREQ = 1'b0;
    RREQ = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
  endtask

  // One modelled cycle: queue model predicts count, pulses, data.
  task automatic cyc(input logic w,
                     input logic [7:0] d,
                     input logic r);
    int n;
    logic we, re, eo, eu;
    logic [7:0] pop;
    n  = q.size();
    we = w && (n < 16);
    re = r && (n > 0);
    eo = w && (n == 16);
    eu = r && (n == 0);
    pop = 8'h00;
    if (n > 0) chk("fwft_head", rd1, q[0]);
    else       chk("fwft_zero", rd1, 0);
    WREQ = w;
    WD   = d;
    RREQ = r;
    step();
    if (re) pop = q.pop_front();
    if (we) q.push_back(d);
    chk("cnt", cnt0, q.size());
    chk("ovf", ovf0, eo);
    chk("udf", udf0, eu);
    chk("cnt_max", cnt0 <= 5'd16, 1);
    if (re) chk("rd", rd0, pop);
    WREQ = 1'b0;
    RREQ = 1'b0;
  endtask

  task automatic set_flags(input int k, input int c);
    tv[k].cnt = 5'(c);
    tv[k].f   = (c == 16);
    tv[k].e   = (c == 0);
    tv[k].af  = (c >= 14);
    tv[k].ae  = (c <= 2);
  endtask

  initial begin
    int wr;
    int m;

    // Vector table: fill, overflow, drain, underflow, idle.
    for (int k = 0; k < 16; k++) begin
      tv[k].wreq = 1'b1;
      tv[k].wd   = 8'(k);
      tv[k].rreq = 1'b0;
      tv[k].ovf  = 1'b0;
      tv[k].udf  = 1'b0;
      tv[k].rd   = 8'h00;
      set_flags(k, k + 1);
    end
    tv[16] = '{1'b1, 8'hAA, 1'b0, 5'd16,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    for (int j = 0; j < 16; j++) begin
      tv[17+j].wreq = 1'b0;
      tv[17+j].wd   = 8'h00;
      tv[17+j].rreq = 1'b1;
      tv[17+j].ovf  = 1'b0;
      tv[17+j].udf  = 1'b0;
      tv[17+j].rd   = 8'(j);
      set_flags(17 + j, 15 - j);
    end
    tv[33] = '{1'b0, 8'h00, 1'b1, 5'd0,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0F};
    tv[34] = '{1'b0, 8'h00, 1'b0, 5'd0,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F};

    // Reset state.
    #12;
    chk("rst_e",   e0,   1);
    chk("rst_ae",  ae0,  1);
    chk("rst_f",   f0,   0);
    chk("rst_af",  af0,  0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_rd",  rd0,  0);
    chk("rst_rd1", rd1,  0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_udf", udf0, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("idle_cnt", cnt0, 0);
    chk("idle_e",   e0,   1);

    // Asynchronous reset in the middle of a fill.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0);
    chk("mid_cnt5", cnt0, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("async_cnt", cnt0, 0);
    chk("async_e",   e0,   1);
    chk("async_rd1", rd1,  0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_udf", udf0, 1);

    // Table-driven fill/drain on the standard-read instance.
    rst_dut();
    for (int k = 0; k < 35; k++) begin
      WREQ = tv[k].wreq;
      WD   = tv[k].wd;
      RREQ = tv[k].rreq;
      step();
      chk($sformatf("tv%0d_cnt", k), cnt0, tv[k].cnt);
      chk($sformatf("tv%0d_f", k),   f0,   tv[k].f);
      chk($sformatf("tv%0d_e", k),   e0,   tv[k].e);
      chk($sformatf("tv%0d_af", k),  af0,  tv[k].af);
      chk($sformatf("tv%0d_ae", k),  ae0,  tv[k].ae);
      chk($sformatf("tv%0d_ovf", k), ovf0, tv[k].ovf);
      chk($sformatf("tv%0d_udf", k), udf0, tv[k].udf);
      chk($sformatf("tv%0d_rd", k),  rd0,  tv[k].rd);
    end
    WREQ = 1'b0;
    RREQ = 1'b0;

    // Simultaneous read/write at mid level, full and empty.
    rst_dut();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'h20 + 8'(i), 1'b1);
      chk("both_cnt8", cnt0, 8);
    end
    m = 0;
    while (q.size() < 16) begin
      cyc(1'b1, 8'h60 + 8'(m), 1'b0);
      m++;
    end
    cyc(1'b1, 8'hEE, 1'b1);
    chk("full_both_cnt", cnt0, 15);
    chk("full_both_ovf", ovf0, 1);
    while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h77, 1'b1);
    chk("empty_both_cnt", cnt0, 1);
    chk("empty_both_udf", udf0, 1);
    cyc(1'b0, 8'h00, 1'b1);

    // First-word-fall-through behaviour.
    rst_dut();
    cyc(1'b1, 8'h5A, 1'b0);
    chk("fwft_5a", rd1, 8'h5A);
    chk("fwft_cnt1", cnt1, 1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("fwft_hold", rd1, 8'h5A);
    cyc(1'b1, 8'h5B, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("fwft_5b", rd1, 8'h5B);
    chk("fwft_cnt", cnt1, 1);

    // Pointer wrap: fill 10 / drain 7 rounds, 48 words total.
    rst_dut();
    wr = 0;
    while (wr < 48) begin
      for (int i = 0; i < 10; i++) begin
        if (wr < 48 && q.size() < 16) begin
          cyc(1'b1, 8'h80 + 8'(wr), 1'b0);
          wr++;
        end
      end
      for (int i = 0; i < 7; i++) begin
        if (q.size() > 0) cyc(1'b0, 8'h00, 1'b1);
      end
    end
    while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1);
    chk("wrap_e", e0, 1);
    chk("wrap_cnt", cnt0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
